// File: rtl/vm_credit_engine.sv
// vm_credit_engine: credit tracking, item dispensing, return timeout and
// greedy one-coin-per-cycle change return for the vending machine.
// Optional feature macro: VM_COIN_INVENTORY_EN adds per-coin inventory
// counters and the o_inventory port (coin supply is unlimited without it).
module vm_credit_engine #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 31,
  parameter int WAIT_TIME  = 100,
  parameter int WAIT_BITS  = 8,
  parameter int INV_BITS   = 8,
  parameter int INIT_COUNT = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_COINS-1:0]            i_input_coin,
  input  logic [NUM_ITEMS-1:0]            i_select_item,
  input  logic                            i_trigger_return,
  input  logic [NUM_COINS*TOTAL_BITS-1:0] coin_value,
  input  logic [NUM_ITEMS*TOTAL_BITS-1:0] item_price,
  output logic [NUM_ITEMS-1:0]            o_available_item,
  output logic [NUM_ITEMS-1:0]            o_output_item,
  output logic [NUM_COINS-1:0]            o_return_coin,
  output logic                            o_coin_reject,
  output logic                            o_busy,
  output logic [TOTAL_BITS-1:0]           o_credit,
  output logic [WAIT_BITS-1:0]            o_wait_time
`ifdef VM_COIN_INVENTORY_EN
  ,
  output logic [NUM_COINS*INV_BITS-1:0]   o_inventory
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  localparam logic [WAIT_BITS-1:0]    WAIT_RELOAD = WAIT_BITS'(WAIT_TIME);
  localparam logic [TOTAL_BITS+1:0]   CREDIT_MAX  = {2'b00, {TOTAL_BITS{1'b1}}};

  // Configuration sanity: the timer must be able to hold its reload value
  // and the inventory counters their reset value.
  if ((WAIT_TIME < 1) || (WAIT_TIME >= (1 << WAIT_BITS))) begin : g_bad_wait
    $error("vm_credit_engine: WAIT_TIME out of range for WAIT_BITS");
  end
  if ((INIT_COUNT < 0) || (INIT_COUNT >= (1 << INV_BITS))) begin : g_bad_inv
    $error("vm_credit_engine: INIT_COUNT out of range for INV_BITS");
  end

  state_t                  state_q, state_d;
  logic [TOTAL_BITS-1:0]   credit_q, credit_d;
  logic [WAIT_BITS-1:0]    wait_q, wait_d;
  logic [NUM_ITEMS-1:0]    item_q, item_d;
  logic [NUM_COINS-1:0]    ret_q, ret_d;
  logic                    reject_q, reject_d;

  logic [TOTAL_BITS:0]     coin_sum_s;
  logic [TOTAL_BITS+1:0]   credit_plus_s;
  logic                    coin_any_s, coin_ok_s, coin_accept_s;
  logic                    sel_onehot_s, sel_valid_s;
  logic [TOTAL_BITS-1:0]   sel_price_s;
  logic [NUM_COINS-1:0]    ret_pick_s, ret_take_s;
  logic [TOTAL_BITS-1:0]   ret_value_s;
  logic [NUM_COINS-1:0]    inv_avail_s, inv_sat_s;

`ifdef VM_COIN_INVENTORY_EN
  logic [NUM_COINS-1:0][INV_BITS-1:0] inv_q, inv_d;

  // Inventory flags: a coin can be paid out when stocked, and blocks an
  // insertion when its counter is already full.
  always_comb begin
    inv_avail_s = '0;
    inv_sat_s   = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      inv_avail_s[k] = (inv_q[k] != '0);
      inv_sat_s[k]   = (inv_q[k] == '1);
    end
  end

  // Inventory next state: accepted coins go in, returned coins come out.
  always_comb begin
    inv_d = inv_q;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (coin_accept_s && i_input_coin[k]) begin
        inv_d[k] = inv_q[k] + INV_BITS'(1);
      end else if (ret_take_s[k]) begin
        inv_d[k] = inv_q[k] - INV_BITS'(1);
      end else begin
        inv_d[k] = inv_q[k];
      end
    end
  end

  // Inventory registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      inv_q <= {NUM_COINS{INV_BITS'(INIT_COUNT)}};
    end else begin
      inv_q <= inv_d;
    end
  end

  assign o_inventory = inv_q;
`else
  // Unlimited coin supply: every coin is always available, never full.
  assign inv_avail_s = {NUM_COINS{1'b1}};
  assign inv_sat_s   = {NUM_COINS{1'b0}};
`endif

  // Datapath decode: insertion sum, select check and greedy coin pick.
  always_comb begin
    coin_sum_s  = '0;
    sel_price_s = '0;
    ret_pick_s  = '0;
    ret_value_s = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (i_input_coin[k]) begin
        coin_sum_s = coin_sum_s + {1'b0, coin_value[k*TOTAL_BITS +: TOTAL_BITS]};
      end else begin
        coin_sum_s = coin_sum_s;
      end
      // Ascending scan: the last fitting coin is the largest one.
      if ((coin_value[k*TOTAL_BITS +: TOTAL_BITS] <= credit_q) && inv_avail_s[k]) begin
        ret_pick_s    = '0;
        ret_pick_s[k] = 1'b1;
        ret_value_s   = coin_value[k*TOTAL_BITS +: TOTAL_BITS];
      end else begin
        ret_pick_s = ret_pick_s;
      end
    end
    for (int k = 0; k < NUM_ITEMS; k++) begin
      if (i_select_item[k]) begin
        sel_price_s = sel_price_s | item_price[k*TOTAL_BITS +: TOTAL_BITS];
      end else begin
        sel_price_s = sel_price_s;
      end
    end
  end

  assign coin_any_s    = |i_input_coin;
  assign credit_plus_s = {2'b00, credit_q} + {1'b0, coin_sum_s};
  assign coin_ok_s     = coin_any_s && (credit_plus_s <= CREDIT_MAX) &&
                         !(|(i_input_coin & inv_sat_s));
  assign coin_accept_s = coin_ok_s &&
                         ((state_q == ST_IDLE) ||
                          ((state_q == ST_CREDIT) && !i_trigger_return));
  assign sel_onehot_s  = (i_select_item != '0) &&
                         ((i_select_item & (i_select_item - NUM_ITEMS'(1))) == '0);
  assign sel_valid_s   = sel_onehot_s && !coin_any_s && (sel_price_s <= credit_q);
  assign ret_take_s    = (state_q == ST_RETURN) ? ret_pick_s : '0;

  // Next-state and registered-output logic, in event priority order.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    wait_d   = wait_q;
    item_d   = '0;
    ret_d    = '0;
    reject_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coin_any_s) begin
          if (coin_ok_s) begin
            credit_d = credit_plus_s[TOTAL_BITS-1:0];
            wait_d   = WAIT_RELOAD;
            state_d  = ST_CREDIT;
          end else begin
            reject_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CREDIT: begin
        if (i_trigger_return) begin
          // Return wins; a coin arriving alongside it bounces back.
          state_d  = ST_RETURN;
          wait_d   = '0;
          reject_d = coin_any_s;
        end else if (coin_any_s) begin
          if (coin_ok_s) begin
            credit_d = credit_plus_s[TOTAL_BITS-1:0];
            wait_d   = WAIT_RELOAD;
          end else begin
            reject_d = 1'b1;
          end
        end else if (sel_valid_s) begin
          item_d   = i_select_item;
          credit_d = credit_q - sel_price_s;
          wait_d   = WAIT_RELOAD;
        end else if (wait_q <= WAIT_BITS'(1)) begin
          state_d = ST_RETURN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q - WAIT_BITS'(1);
        end
      end
      ST_RETURN: begin
        reject_d = coin_any_s;
        if (ret_pick_s != '0) begin
          ret_d    = ret_pick_s;
          credit_d = credit_q - ret_value_s;
        end else begin
          // Sub-coin residue is forfeited.
          state_d  = ST_IDLE;
          credit_d = '0;
          wait_d   = WAIT_RELOAD;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        wait_d   = WAIT_RELOAD;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      wait_q   <= WAIT_RELOAD;
      item_q   <= '0;
      ret_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      wait_q   <= wait_d;
      item_q   <= item_d;
      ret_q    <= ret_d;
      reject_q <= reject_d;
    end
  end

  // Affordability flags, decoded from registered state only.
  always_comb begin
    o_available_item = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      o_available_item[k] = (state_q == ST_CREDIT) &&
                            (item_price[k*TOTAL_BITS +: TOTAL_BITS] <= credit_q);
    end
  end

  assign o_output_item = item_q;
  assign o_return_coin = ret_q;
  assign o_coin_reject = reject_q;
  assign o_busy        = (state_q == ST_RETURN);
  assign o_credit      = credit_q;
  assign o_wait_time   = wait_q;

endmodule

// File: doc/vm_credit_engine.md
Name: vm_credit_engine

Overview:
Parametrised successor of the vending-machine time/coin checker. Tracks inserted credit, dispenses affordable items, and runs a return-timeout counter. On timeout or a return request, it pays change back through a greedy multi-cycle FSM that returns one coin per cycle. It sits between the coin/item front panel and the dispenser/change hopper in the vending_machine top.

Parameters:
NUM_COINS, 3, number of coin denominations; coin index 0 is the smallest, and values are strictly ascending with index
NUM_ITEMS, 4, number of selectable items
TOTAL_BITS, 31, credit register width
WAIT_TIME, 100, timeout reload value in cycles; must be at least 1
WAIT_BITS, 8, width of the timeout counter; must satisfy WAIT_TIME < 2^WAIT_BITS
INV_BITS, 8, per-coin inventory counter width (optional feature only)
INIT_COUNT, 4, per-coin inventory value at reset (optional feature only)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
i_input_coin  in  NUM_COINS  coin inserted this cycle; any bit combination allowed
i_select_item  in  NUM_ITEMS  item select; must be one-hot, otherwise ignored
i_trigger_return  in  1  request immediate change return
coin_value  in  NUM_COINS*TOTAL_BITS  flattened coin values; slice k is coin k
item_price  in  NUM_ITEMS*TOTAL_BITS  flattened item prices; slice k is item k
o_available_item  out  NUM_ITEMS  bit k=1 when in CREDIT and item_price[k] <= o_credit (combinational from registers)
o_output_item  out  NUM_ITEMS  one-cycle one-hot dispense pulse, registered
o_return_coin  out  NUM_COINS  one-hot coin returned this cycle, registered
o_coin_reject  out  1  one-cycle pulse: the inserted coin(s) were not accepted
o_busy  out  1  high while in RETURN
o_credit  out  TOTAL_BITS  current credit
o_wait_time  out  WAIT_BITS  remaining timeout cycles

Behaviour:
- Reset: state IDLE; o_credit=0; o_wait_time=WAIT_TIME; o_output_item, o_return_coin and o_coin_reject all 0. Reset wins over every other input and aborts a RETURN in progress immediately; unreturned credit is discarded.
- States and transitions:
  - IDLE: credit is 0 and the timer holds WAIT_TIME. Go to CREDIT on an accepted coin insert.
  - CREDIT: accepts coins and selects.
  - RETURN: pays change. Returns to IDLE when the change loop finishes.
- Coin insert (IDLE or CREDIT):
  - sum = total coin_value over the set bits of i_input_coin, computed at TOTAL_BITS+1 width.
  - If credit+sum > 2^TOTAL_BITS-1, reject the whole insertion: o_coin_reject=1 next cycle, credit unchanged.
  - Otherwise credit+=sum next cycle and o_wait_time reloads to WAIT_TIME.
- Select (CREDIT only):
  - Valid only when the input is one-hot, no coin is inserted the same cycle, and item_price[k] <= credit.
  - On a valid select: o_output_item[k]=1 next cycle, credit -= price, timer reloads.
  - Any other select is silently ignored.
- Simultaneous events, in priority order: reset > i_trigger_return > coin > select > timer decrement.
- Timer: in CREDIT it decrements by 1 per cycle when neither a coin nor a valid select occurs. On the cycle it equals 1 and would reach 0, or on i_trigger_return, go to RETURN next cycle with o_wait_time=0. i_trigger_return in IDLE is ignored.
- RETURN:
  - Each cycle, pick the highest index j with coin_value[j] <= credit.
  - Drive o_return_coin=one-hot(j) the next cycle and subtract coin_value[j] from credit.
  - When no coin fits (credit < coin_value[0], including 0): go to IDLE, credit cleared to 0 (sub-coin residue forfeited), timer reloads.
  - Coins inserted during RETURN are rejected with an o_coin_reject pulse; selects and i_trigger_return are ignored.
- Latency: one cycle from input to every registered output; one returned coin per cycle.

Optional Feature:
VM_COIN_INVENTORY_EN.
- When defined:
  - Each coin k has an INV_BITS counter, reset to INIT_COUNT.
  - An accepted insert increments the counters of the coins inserted. If any of those counters is saturated, the entire insertion is rejected.
  - The greedy return only picks coins whose count is > 0 and decrements that count.
  - Add an output port o_inventory (NUM_COINS*INV_BITS).
- When undefined: the coin supply is unlimited, there are no inventory counters, and the o_inventory port is absent.

Test Plan:
(Defaults throughout; coin_value = 100/500/1000; item_price = 400/500/1000/2000.)
1. Insert coin2, then coin1 on the next cycle -> o_credit 1000 then 1500; o_available_item=4'b0111; o_wait_time=100 after each insert.
2. With credit 1500, select 4'b0010 -> o_output_item=4'b0010 for one cycle; o_credit=1000; select 4'b1000 -> ignored, credit unchanged.
3. With credit 1600, pulse i_trigger_return -> o_return_coin sequence 100b, 010b, 001b on consecutive cycles; o_busy high for 4 cycles; o_credit ends at 0.
4. Insert 500 and wait 100 idle cycles -> RETURN entered on schedule; o_return_coin=010b once, then IDLE.
5. During RETURN, insert coin0 -> o_coin_reject pulses; credit sequence unaffected. Assert reset mid-RETURN -> outputs reach reset values next cycle.
6. With VM_COIN_INVENTORY_EN, INIT_COUNT=0 for coin2 and credit 1000 returning -> two 010b coins returned, no 100b; o_inventory reflects the decrements.
